// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory-access stage: funct3 encodings, LSU states,
// and access-size decode.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

  // 0 marks the 111 no-op encoding, which has no meaningful size.
  function automatic logic [3:0] size_bytes(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: size_bytes = 4'd1;
      F3_H, F3_HU: size_bytes = 4'd2;
      F3_W, F3_WU: size_bytes = 4'd4;
      F3_D:        size_bytes = 4'd8;
      default:     size_bytes = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_extend.sv
// Turns eight raw little-endian bytes into the sign- or zero-extended load
// value selected by funct3; the 111 encoding yields zero.
module load_extend
  import riscv_mem_pkg::*;
(
  input  logic [63:0] raw,
  input  logic [2:0]  funct3,
  output logic [63:0] ext
);

  always_comb begin
    ext = '0;
    case (funct3)
      F3_B:    ext = {{56{raw[7]}}, raw[7:0]};
      F3_H:    ext = {{48{raw[15]}}, raw[15:0]};
      F3_W:    ext = {{32{raw[31]}}, raw[31:0]};
      F3_D:    ext = raw;
      F3_BU:   ext = {56'd0, raw[7:0]};
      F3_HU:   ext = {48'd0, raw[15:0]};
      F3_WU:   ext = {32'd0, raw[31:0]};
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-access stage: wait-stated, byte-addressable little-endian data memory
// with sub-word loads/stores. Optional macro MISALIGN_TRAP_EN enables the misalign trap.
//
// state  | meaning
// IDLE   | waiting for MemRead/MemWrite; request latched on arrival
// ACCESS | counting down wait states; access performed when counter hits 0
// DONE   | result visible, stall released, request inputs ignored
module mem_stage_lsu
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 512,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [63:0] Address,
  input  logic [63:0] Write_Data,
  output logic [63:0] Read_Data,
  output logic        stall,
  output logic        misalign
);

  localparam int AW = $clog2(DEPTH_BYTES);

  lsu_state_t state, state_nxt;

  logic [3:0]    cnt;
  logic [AW-1:0] addr_q;
  logic [63:0]   wdata_q;
  logic [2:0]    f3_q;
  logic          store_q;
  logic          mis_q;
  logic [7:0]    mem [DEPTH_BYTES];
  logic [63:0]   raw_bytes;
  logic [63:0]   ext_data;
  logic [3:0]    st_size;
  logic          req;
  logic          commit;
  logic          unused_addr;

  assign req         = MemRead | MemWrite;
  assign commit      = (state == ACCESS) && (cnt == 4'd0);
  assign st_size     = size_bytes(f3_q);
  assign unused_addr = ^Address[63:AW];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall    = 1'b0;
    misalign = 1'b0;
    case (state)
      IDLE:    stall = req & ~reset;
      ACCESS:  stall = ~reset;
      DONE:    misalign = mis_q;
      default: stall = 1'b0;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic [3:0] req_size;
  assign req_size = size_bytes(funct3);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      store_q   <= 1'b0;
      mis_q     <= 1'b0;
      Read_Data <= '0;
    end else begin
      if (state == IDLE && req) begin
        addr_q  <= Address[AW-1:0];
        wdata_q <= Write_Data;
        f3_q    <= funct3;
        store_q <= MemWrite;
        cnt     <= 4'(WAIT_STATES);
`ifdef MISALIGN_TRAP_EN
        mis_q   <= (req_size != 4'd0) && ((Address[3:0] & (req_size - 4'd1)) != 4'd0);
`else
        mis_q   <= 1'b0;
`endif
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !store_q)
        Read_Data <= mis_q ? 64'd0 : ext_data;
    end
  end

  // Write and read ports both wrap modulo the memory size through the AW-bit index.
  always_ff @(posedge clk) begin
    if (!reset && commit && store_q && !f3_q[2] && !mis_q) begin
      for (int i = 0; i < 8; i++)
        if (i < int'(st_size))
          mem[addr_q + AW'(i)] <= wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    raw_bytes = '0;
    for (int i = 0; i < 8; i++)
      raw_bytes[8*i +: 8] = mem[addr_q + AW'(i)];
  end

  load_extend u_load_extend (
    .raw    (raw_bytes),
    .funct3 (f3_q),
    .ext    (ext_data)
  );

endmodule
